// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the execute-stage ALU.
//   alu_op_e : decoded operation
//   FN_*     : R-type funct field encodings
//   ALUOP_*  : main-control aluop encodings
//   state_e  : execute-unit FSM states
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_MULT,
    OP_MULTU,
    OP_ILLEGAL
  } alu_op_e;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational ALU control decode.
//   aluop     in  main-control ALU class
//   funct     in  instruction funct field (R-type only)
//   ori_sel   in  immediate OR select (aluop 00)
//   bneal_sel in  branch-and-link compare select (aluop 00)
//   op        out decoded operation, OP_ILLEGAL for unknown encodings
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  input  logic       ori_sel,
  input  logic       bneal_sel,
  output alu_op_e    op
);

  always_comb begin
    op = OP_ILLEGAL;
    case (aluop)
      // ori_sel wins over bneal_sel when both are set
      ALUOP_MEM:  op = ori_sel ? OP_OR : (bneal_sel ? OP_SUB : OP_ADD);
      ALUOP_BR:   op = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:   op = OP_ADD;
          FN_SUB:   op = OP_SUB;
          FN_AND:   op = OP_AND;
          FN_OR:    op = OP_OR;
          FN_SLT:   op = OP_SLT;
          FN_SLL:   op = OP_SLL;
          FN_SRL:   op = OP_SRL;
          FN_SRA:   op = OP_SRA;
          FN_MULT:  op = OP_MULT;
          FN_MULTU: op = OP_MULTU;
          default:  op = OP_ILLEGAL;
        endcase
      end
      ALUOP_RSVD: op = OP_ILLEGAL;
      default:    op = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute-stage ALU with integrated control decode.
// Single-cycle ops complete one cycle after start; MULT/MULTU run an
// iterative shift-add over WIDTH cycles while busy is high.
//   clk, reset           clock, asynchronous active-high reset
//   start                op request, only honoured in IDLE
//   aluop, funct         control inputs for decode
//   ori_sel, bneal_sel   aluop-00 sub-selects
//   a, b, shamt          operands and shift amount
//   busy                 multiply in progress
//   done                 one-cycle completion pulse
//   result, hi, zero     result (LO for multiply), multiply HI, result==0
//   err                  last completed op was an illegal decode
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic             ori_sel,
  input  logic             bneal_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             err
);

  localparam int                 W2      = 2 * WIDTH;
  localparam logic [SHW:0]       CNT_MAX = (SHW + 1)'(WIDTH);
  localparam logic [SHW:0]       CNT_ONE = (SHW + 1)'(1);

  alu_op_e op;

  alu_decode u_dec (
    .aluop     (aluop),
    .funct     (funct),
    .ori_sel   (ori_sel),
    .bneal_sel (bneal_sel),
    .op        (op)
  );

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right each step
  logic [SHW:0]     cnt_q, cnt_d;
  logic             neg_q, neg_d;

  // Single-cycle datapath
  logic [WIDTH-1:0] alu_res;
  logic             slt;

  assign slt = $signed(a) < $signed(b);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Signed multiply runs on magnitudes; the most-negative value maps to
  // itself, which is its correct unsigned magnitude.
  logic             is_mul, is_smul;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    step_acc, prod;

  assign is_smul  = (op == OP_MULT);
  assign is_mul   = is_smul || (op == OP_MULTU);
  assign a_mag    = (is_smul && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag    = (is_smul && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod     = neg_q ? (~step_acc + 1'b1) : step_acc;

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    err_d    = err_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = is_smul && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_d    = '0;
            cnt_d    = CNT_MAX;
            state_d  = ST_MUL;
          end else begin
            // ILLEGAL yields alu_res == 0, so zero follows naturally
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            err_d    = (op == OP_ILLEGAL);
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          {hi_d, result_d} = prod;
          zero_d  = (prod[WIDTH-1:0] == '0);
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign busy   = (state_q == ST_MUL);
  assign done   = done_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic        ori_sel, bneal_sel;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [7:0]  a8, b8;
  logic [2:0]  shamt8;
  logic        busy, done, zero, err;
  logic [31:0] result, hi;
  logic        busy8, done8, zero8, err8;
  logic [7:0]  result8, hi8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
    .ori_sel(ori_sel), .bneal_sel(bneal_sel), .a(a), .b(b), .shamt(shamt),
    .busy(busy), .done(done), .result(result), .hi(hi), .zero(zero), .err(err)
  );

  alu_exec_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .aluop(aluop), .funct(funct),
    .ori_sel(ori_sel), .bneal_sel(bneal_sel), .a(a8), .b(b8), .shamt(shamt8),
    .busy(busy8), .done(done8), .result(result8), .hi(hi8), .zero(zero8), .err(err8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: returns {kind, value}; kind 0 = single-cycle,
  // 1 = illegal, 2 = multiply (value is the full 64-bit product).
  function automatic logic [65:0] golden(input logic [1:0] op, input logic [5:0] fn,
                                         input logic ori, input logic bn,
                                         input logic [31:0] x, input logic [31:0] y,
                                         input logic [4:0] sh);
    logic [31:0] r;
    logic [1:0]  k;
    logic [63:0] p;
    r = '0; k = 2'd0; p = '0;
    case (op)
      2'd0: r = ori ? (x | y) : (bn ? x - y : x + y);
      2'd1: r = x - y;
      2'd2: begin
        case (fn)
          6'h20: r = x + y;
          6'h22: r = x - y;
          6'h24: r = x & y;
          6'h25: r = x | y;
          6'h2a: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          6'h00: r = y << sh;
          6'h02: r = y >> sh;
          6'h03: r = 32'($signed(y) >>> sh);
          6'h18: begin k = 2'd2; p = 64'(longint'($signed(x)) * longint'($signed(y))); end
          6'h19: begin k = 2'd2; p = {32'b0, x} * {32'b0, y}; end
          default: k = 2'd1;
        endcase
      end
      default: k = 2'd1;
    endcase
    if (k != 2'd2) p = {32'b0, r};
    return {k, p};
  endfunction

  logic [65:0] g;
  assign g = golden(aluop, funct, ori_sel, bneal_sel, a, b, shamt);

  logic        m_busy, m_done, m_zero, m_err;
  logic [31:0] m_res, m_hi;
  logic [63:0] m_prod;
  int          m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_hi <= '0;
      m_zero <= 1'b1; m_err <= 1'b0; m_cnt <= 0; m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_prod[63:32];
          m_res  <= m_prod[31:0];
          m_zero <= (m_prod[31:0] == 32'd0);
          m_err  <= 1'b0;
        end
      end else if (start) begin
        if (g[65:64] == 2'd2) begin
          m_busy <= 1'b1;
          m_cnt  <= 32;
          m_prod <= g[63:0];
        end else begin
          m_done <= 1'b1;
          m_res  <= g[31:0];
          m_zero <= (g[31:0] == 32'd0);
          m_err  <= (g[65:64] == 2'd1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_busy",   busy,   m_busy);
      chk("m_done",   done,   m_done);
      chk("m_result", result, m_res);
      chk("m_hi",     hi,     m_hi);
      chk("m_zero",   zero,   m_zero);
      chk("m_err",    err,    m_err);
    end
  end

  task automatic setop(input logic [1:0] op, input logic [5:0] fn, input logic o,
                       input logic bn, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh);
    aluop = op; funct = fn; ori_sel = o; bneal_sel = bn; a = x; b = y; shamt = sh;
  endtask

  task automatic go();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    while (!done && lat < limit) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone;
    logic [31:0] r_at, h_at;
    reset = 1'b1; start = 1'b0; start8 = 1'b0;
    a8 = '0; b8 = '0; shamt8 = '0;
    setop(2'd0, 6'h00, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_res", result, 0);  chk("rst_hi", hi, 0);
    chk("rst_zero", zero, 1);   chk("rst_err", err, 0);
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    // reset asserted mid-multiply
    setop(2'd2, 6'h18, 1'b0, 1'b0, 32'h12345, 32'h777, 5'd0);
    go();
    repeat (9) @(posedge clk);
    #2 chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0); chk("mid_done", done, 0);
    chk("mid_res", result, 0); chk("mid_hi", hi, 0); chk("mid_zero", zero, 1);
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    setop(2'd2, 6'h20, 1'b0, 1'b0, 32'd5, 32'd7, 5'd0); go();
    chk("add_res", result, 12); chk("add_done", done, 1);

    setop(2'd2, 6'h2a, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd0); go();
    chk("slt_res", result, 1);

    setop(2'd2, 6'h22, 1'b0, 1'b0, 32'h1234, 32'h1234, 5'd0); go();
    chk("sub_res", result, 0); chk("sub_zero", zero, 1);

    setop(2'd0, 6'h22, 1'b1, 1'b1, 32'hF0, 32'h0F, 5'd0); go();
    chk("ori_prio", result, 32'hFF);

    setop(2'd0, 6'h00, 1'b0, 1'b1, 32'd10, 32'd3, 5'd0); go();
    chk("bneal_sub", result, 7);

    setop(2'd1, 6'h00, 1'b0, 1'b0, 32'd3, 32'd5, 5'd0); go();
    chk("br_sub", result, 32'hFFFFFFFE);

    // MULT -2 * 3, then a single-cycle op in the done cycle
    setop(2'd2, 6'h18, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd3, 5'd0); go();
    wait_done(40, lat);
    chk("mult_lat", lat + 1, 33);
    chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", result, 32'hFFFFFFFA);
    setop(2'd2, 6'h20, 1'b0, 1'b0, 32'd1, 32'd1, 5'd0); go();
    chk("after_mul_add", result, 2); chk("after_mul_hi", hi, 32'hFFFFFFFF);

    setop(2'd2, 6'h19, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd3, 5'd0); go();
    wait_done(40, lat);
    chk("multu_hi", hi, 2); chk("multu_lo", result, 32'hFFFFFFFA);

    setop(2'd2, 6'h18, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 5'd0); go();
    wait_done(40, lat);
    chk("mneg_hi", hi, 32'h40000000); chk("mneg_lo", result, 0); chk("mneg_zero", zero, 1);

    // start hammered during MUL with changing operands
    setop(2'd2, 6'h18, 1'b0, 1'b0, 32'd7, 32'hFFFFFFFF, 5'd0); go();
    ndone = 0; r_at = '0; h_at = '0;
    for (int i = 0; i < 40; i++) begin
      start = busy;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      if (done) begin ndone++; r_at = result; h_at = hi; end
    end
    start = 1'b0;
    chk("ign_ndone", ndone, 1);
    chk("ign_lo", r_at, 32'hFFFFFFF9); chk("ign_hi", h_at, 32'hFFFFFFFF);

    setop(2'd2, 6'h03, 1'b0, 1'b0, 32'd0, 32'h80000000, 5'd4); go();
    chk("sra", result, 32'hF8000000);

    // back-to-back single-cycle ops
    setop(2'd2, 6'h00, 1'b0, 1'b0, 32'd0, 32'd1, 5'd31);
    start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_sll", result, 32'h80000000); chk("b2b_done1", done, 1);
    setop(2'd2, 6'h02, 1'b0, 1'b0, 32'd0, 32'h80000000, 5'd31);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_srl", result, 1); chk("b2b_done2", done, 1);

    setop(2'd2, 6'h3f, 1'b0, 1'b0, 32'd9, 32'd9, 5'd0); go();
    chk("ill_err", err, 1); chk("ill_res", result, 0);
    chk("ill_zero", zero, 1); chk("ill_done", done, 1);
    setop(2'd3, 6'h20, 1'b0, 1'b0, 32'd1, 32'd1, 5'd0); go();
    chk("rsvd_err", err, 1);
    setop(2'd2, 6'h24, 1'b0, 1'b0, 32'hFF00, 32'h0FF0, 5'd0); go();
    chk("and_res", result, 32'h0F00); chk("and_err", err, 0);

    // 8-bit instance: MULT -2 * 3
    aluop = 2'd2; funct = 6'h18; a8 = 8'hFE; b8 = 8'd3;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_lat", lat + 1, 9);
    chk("w8_hi", hi8, 8'hFF); chk("w8_lo", result8, 8'hFA);
    chk("w8_zero", zero8, 0); chk("w8_err", err8, 0); chk("w8_busy", busy8, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
